// File: rtl/sm3_pad_core_pw.sv
// SM3 message padder: forwards message beats, then appends 0x80, zero fill and
// the 64-bit big-endian bit length, emitting 512-bit blocks on a 32/64-bit bus.
module sm3_pad_core_pw #(
    parameter int INPT_DW   = 32,
    parameter int BYTE_W    = INPT_DW / 8,
    parameter int BLK_BEATS = 512 / INPT_DW,
    parameter int LEN_BEATS = 64 / INPT_DW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INPT_DW-1:0] msg_inpt_d,
    input  logic [BYTE_W-1:0]  msg_inpt_vld_byte,
    input  logic               msg_inpt_vld,
    input  logic               msg_inpt_lst,
    output logic               msg_inpt_rdy,
    input  logic               pad_otpt_ena,
    output logic [INPT_DW-1:0] pad_otpt_d,
    output logic               pad_otpt_vld,
    output logic               pad_otpt_blk_lst,
    output logic               pad_otpt_lst
);

    localparam int CNT_W = $clog2(BLK_BEATS);
    localparam int POP_W = $clog2(BYTE_W + 1);
    localparam logic [CNT_W-1:0] LEN_IDX  = CNT_W'(BLK_BEATS - LEN_BEATS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLK_BEATS - 1);
    localparam logic [INPT_DW-1:0] MARK_BEAT = {8'h80, {(INPT_DW - 8){1'b0}}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DATA    = 3'd1,
        PAD_10  = 3'd2,
        PAD_00  = 3'd3,
        PAD_LEN = 3'd4
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   beat_cnt_reg;
    logic [60:0]        byte_cnt_reg;
    logic [63:0]        len_shift_reg;
    logic               run_reg;

    logic               advance;
    logic               accept;
    logic               emit;
    logic [POP_W-1:0]   byte_pop;
    logic [60:0]        byte_cnt_next;
    logic [CNT_W-1:0]   beat_idx_next;
    state_t             pad_route;
    logic [INPT_DW-1:0] tail_d;

    // run_reg keeps ready low while reset is held and for the first edge after
    assign advance       = pad_otpt_ena | ~pad_otpt_vld;
    assign msg_inpt_rdy  = run_reg && ((state_reg == IDLE) || (state_reg == DATA)) && advance;
    assign accept        = msg_inpt_vld && msg_inpt_rdy;
    assign emit          = accept || (state_reg == PAD_10) || (state_reg == PAD_00)
                           || (state_reg == PAD_LEN);
    assign beat_idx_next = beat_cnt_reg + CNT_W'(1);
    assign pad_route     = (beat_idx_next == LEN_IDX) ? PAD_LEN : PAD_00;
    assign byte_cnt_next = byte_cnt_reg + 61'(byte_pop);

    always_comb begin
        byte_pop = '0;
        for (int i = 0; i < BYTE_W; i++) begin
            byte_pop = byte_pop + POP_W'(msg_inpt_vld_byte[i]);
        end
    end

    // Final partial beat: keep valid bytes, 0x80 in the first empty lane, zeros after
    genvar gi;
    generate
        for (gi = 0; gi < BYTE_W; gi++) begin : g_lane
            localparam int HI = INPT_DW - 1 - 8 * gi;
            logic lane_vld;
            logic lane_mark;
            assign lane_vld = msg_inpt_vld_byte[BYTE_W-1-gi];
            if (gi == 0) begin : g_head
                assign lane_mark = 1'b1;
            end else begin : g_body
                assign lane_mark = msg_inpt_vld_byte[BYTE_W-gi];
            end
            assign tail_d[HI -: 8] = lane_vld  ? msg_inpt_d[HI -: 8] :
                                     lane_mark ? 8'h80 : 8'h00;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            beat_cnt_reg     <= '0;
            byte_cnt_reg     <= '0;
            len_shift_reg    <= '0;
            run_reg          <= 1'b0;
            pad_otpt_d       <= '0;
            pad_otpt_vld     <= 1'b0;
            pad_otpt_blk_lst <= 1'b0;
            pad_otpt_lst     <= 1'b0;
        end else begin
            run_reg <= 1'b1;
            if (advance) begin
                if (emit) begin
                    pad_otpt_vld     <= 1'b1;
                    pad_otpt_blk_lst <= (beat_cnt_reg == LAST_IDX);
                    pad_otpt_lst     <= 1'b0;
                    beat_cnt_reg     <= beat_idx_next;
                end else begin
                    pad_otpt_vld     <= 1'b0;
                    pad_otpt_blk_lst <= 1'b0;
                    pad_otpt_lst     <= 1'b0;
                end
                case (state_reg)
                    IDLE, DATA: begin
                        if (accept) begin
                            byte_cnt_reg <= byte_cnt_next;
                            if (!msg_inpt_lst) begin
                                pad_otpt_d <= msg_inpt_d;
                                state_reg  <= DATA;
                            end else begin
                                // Length is frozen here; the counter itself clears on return to IDLE
                                len_shift_reg <= {byte_cnt_next, 3'b000};
                                if (&msg_inpt_vld_byte) begin
                                    pad_otpt_d <= msg_inpt_d;
                                    state_reg  <= PAD_10;
                                end else begin
                                    pad_otpt_d <= tail_d;
                                    state_reg  <= pad_route;
                                end
                            end
                        end
                    end
                    PAD_10: begin
                        pad_otpt_d <= MARK_BEAT;
                        state_reg  <= pad_route;
                    end
                    PAD_00: begin
                        pad_otpt_d <= '0;
                        state_reg  <= pad_route;
                    end
                    PAD_LEN: begin
                        pad_otpt_d    <= len_shift_reg[63 -: INPT_DW];
                        len_shift_reg <= len_shift_reg << INPT_DW;
                        if (beat_cnt_reg == LAST_IDX) begin
                            pad_otpt_lst <= 1'b1;
                            byte_cnt_reg <= '0;
                            state_reg    <= IDLE;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sm3_pad_core_pw.sv
// Bench for sm3_pad_core_pw: 32- and 64-bit instances checked beat by beat
// against a byte-level padding model, plus directed boundary and reset cases.
module tb_sm3_pad_core_pw;

    typedef struct packed {
        logic [63:0] d;
        logic        blk;
        logic        lst;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m32_d;
    logic [3:0]  m32_vb;
    logic        m32_vld, m32_lst, m32_rdy, ena32;
    logic [31:0] o32_d;
    logic        o32_vld, o32_blk, o32_lst;
    logic [63:0] m64_d;
    logic [7:0]  m64_vb;
    logic        m64_vld, m64_lst, m64_rdy, ena64;
    logic [63:0] o64_d;
    logic        o64_vld, o64_blk, o64_lst;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  msg_q[$];
    beat_t       exp32[$];
    beat_t       exp64[$];
    beat_t       chk_q[$];
    int          out_cnt32 = 0;
    int          bp_mode   = 0;
    int          bp_base   = 0;
    int          last_st   = -1;

    always #5 clk = ~clk;

    sm3_pad_core_pw #(.INPT_DW(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .msg_inpt_d(m32_d), .msg_inpt_vld_byte(m32_vb), .msg_inpt_vld(m32_vld),
        .msg_inpt_lst(m32_lst), .msg_inpt_rdy(m32_rdy), .pad_otpt_ena(ena32),
        .pad_otpt_d(o32_d), .pad_otpt_vld(o32_vld), .pad_otpt_blk_lst(o32_blk),
        .pad_otpt_lst(o32_lst)
    );

    sm3_pad_core_pw #(.INPT_DW(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .msg_inpt_d(m64_d), .msg_inpt_vld_byte(m64_vb), .msg_inpt_vld(m64_vld),
        .msg_inpt_lst(m64_lst), .msg_inpt_rdy(m64_rdy), .pad_otpt_ena(ena64),
        .pad_otpt_d(o64_d), .pad_otpt_vld(o64_vld), .pad_otpt_blk_lst(o64_blk),
        .pad_otpt_lst(o64_lst)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Legal byte valids: MSB set, no 1 after a 0, all ones unless last beat
    function automatic bit vb_legal(input logic [7:0] vb, input int w, input logic lst);
        bit seen0 = 0;
        for (int i = w - 1; i >= 0; i--) begin
            if (!vb[i]) seen0 = 1;
            else if (seen0) return 0;
        end
        if (!lst && seen0) return 0;
        return vb[w-1];
    endfunction

    always @(posedge clk) begin
        if (rst_n && m32_vld && m32_rdy)
            assert (vb_legal({4'b0, m32_vb}, 4, m32_lst)) else $error("illegal vld_byte %b on 32-bit input", m32_vb);
        if (rst_n && m64_vld && m64_rdy)
            assert (vb_legal(m64_vb, 8, m64_lst)) else $error("illegal vld_byte %b on 64-bit input", m64_vb);
    end

    // Model: message bytes, 0x80, zeros to 56 mod 64, 8-byte big-endian bit length
    function automatic void make_exp(input bit w64);
        logic [7:0]  p[$];
        logic [63:0] bits;
        beat_t       e;
        int          wb, nb;
        p    = msg_q;
        bits = 64'(msg_q.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        wb = w64 ? 8 : 4;
        nb = p.size() / wb;
        chk_q.delete();
        for (int b = 0; b < nb; b++) begin
            e.d = '0;
            for (int j = 0; j < wb; j++) e.d = (e.d << 8) | 64'(p[b*wb+j]);
            e.blk = (((b + 1) * wb) % 64 == 0);
            e.lst = (b == nb - 1);
            chk_q.push_back(e);
            if (w64) exp64.push_back(e);
            else     exp32.push_back(e);
        end
    endfunction

    task automatic send_msg(input bit w64, input int gap);
        int          wb, n, nb, idx, t;
        logic [63:0] d;
        logic [7:0]  vb;
        bit          acc;
        wb = w64 ? 8 : 4;
        n  = msg_q.size();
        nb = (n + wb - 1) / wb;
        make_exp(w64);
        for (int b = 0; b < nb; b++) begin
            d  = '0;
            vb = '0;
            for (int j = 0; j < wb; j++) begin
                idx = b * wb + j;
                if (idx < n) begin
                    d[63-8*j -: 8] = msg_q[idx];
                    vb[7-j] = 1'b1;
                end
            end
            if (w64) begin
                m64_d = d; m64_vb = vb; m64_lst = (b == nb - 1); m64_vld = 1'b1;
            end else begin
                m32_d = d[63:32]; m32_vb = vb[7:4]; m32_lst = (b == nb - 1); m32_vld = 1'b1;
            end
            t   = 0;
            acc = 0;
            while (!acc && t < 500) begin
                @(negedge clk);
                acc = w64 ? m64_rdy : m32_rdy;
                @(posedge clk);
                #1;
                t++;
            end
            if (!acc) begin
                n_checks++;
                $display("FAIL accept_timeout: beat %0d never accepted, required accept within 500 cycles", b);
            end
            m32_vld = 1'b0;
            m64_vld = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_drain(input bit w64);
        int t = 0;
        while ((w64 ? exp64.size() : exp32.size()) != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk(w64 ? "drain64" : "drain32", 64'(w64 ? exp64.size() : exp32.size()), 64'd0);
    endtask

    task automatic msg_abc();
        msg_q.delete();
        msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
    endtask

    task automatic msg_rep(input logic [31:0] word, input int nwords);
        msg_q.delete();
        for (int i = 0; i < nwords; i++)
            for (int j = 0; j < 4; j++) msg_q.push_back(word[31-8*j -: 8]);
    endtask

    task automatic msg_seq(input int n);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(8'(i + 1));
    endtask

    // Output enable shaping for the 32-bit instance
    initial begin
        int cyc = 0;
        ena32 = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (bp_mode)
                1: begin
                    if (o32_vld && (out_cnt32 - bp_base) inside {3, 4, 5}
                        && (out_cnt32 - bp_base) != last_st) begin
                        ena32   = 1'b0;
                        last_st = out_cnt32 - bp_base;
                    end else ena32 = 1'b1;
                end
                2:       ena32 = ((cyc % 3) != 0);
                default: ena32 = 1'b1;
            endcase
        end
    end

    // Per-cycle compare, 32-bit instance
    initial begin
        logic [31:0] p_d;
        logic [2:0]  p_ctl;
        bit          hold = 0;
        beat_t       e;
        forever begin
            @(negedge clk);
            if (!rst_n) hold = 0;
            else begin
                if (hold) begin
                    chk("hold32_d", 64'(o32_d), 64'(p_d));
                    chk("hold32_ctl", 64'({o32_vld, o32_blk, o32_lst}), 64'(p_ctl));
                end
                if (o32_vld && !ena32) begin
                    chk("stall_rdy32", 64'(m32_rdy), 64'd0);
                    hold  = 1;
                    p_d   = o32_d;
                    p_ctl = {o32_vld, o32_blk, o32_lst};
                end else hold = 0;
                if (o32_vld && ena32) begin
                    if (exp32.size() == 0) begin
                        n_checks++;
                        $display("FAIL extra_beat32: got beat %h, required no beat", o32_d);
                    end else begin
                        e = exp32.pop_front();
                        chk($sformatf("beat32_d[%0d]", out_cnt32), 64'(o32_d), e.d);
                        chk($sformatf("beat32_flags[%0d]", out_cnt32), 64'({o32_blk, o32_lst}), 64'({e.blk, e.lst}));
                    end
                    out_cnt32++;
                end
            end
        end
    end

    // Per-cycle compare, 64-bit instance
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst_n && o64_vld && ena64) begin
                if (exp64.size() == 0) begin
                    n_checks++;
                    $display("FAIL extra_beat64: got beat %h, required no beat", o64_d);
                end else begin
                    e = exp64.pop_front();
                    chk("beat64_d", o64_d, e.d);
                    chk("beat64_flags", 64'({o64_blk, o64_lst}), 64'({e.blk, e.lst}));
                end
            end
        end
    end

    initial begin
        m32_d = '0; m32_vb = '0; m32_vld = 1'b0; m32_lst = 1'b0;
        m64_d = '0; m64_vb = '0; m64_vld = 1'b0; m64_lst = 1'b0;
        ena64 = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_d32", 64'(o32_d), 64'd0);
        chk("rst_ctl32", 64'({o32_vld, o32_blk, o32_lst}), 64'd0);
        chk("rst_rdy32", 64'(m32_rdy), 64'd0);
        chk("rst_d64", o64_d, 64'd0);
        chk("rst_ctl64", 64'({o64_vld, o64_blk, o64_lst, m64_rdy}), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 'abc', 32-bit
        msg_abc();
        send_msg(0, 0);
        chk("model_abc32_n", 64'(chk_q.size()), 64'd16);
        chk("model_abc32_b0", chk_q[0].d, 64'h61626380);
        chk("model_abc32_b15", chk_q[15].d, 64'h18);
        chk("model_abc32_f15", 64'({chk_q[15].blk, chk_q[15].lst}), 64'b11);
        wait_drain(0);

        // 64 bytes full: one extra pad block
        msg_rep(32'h61626364, 16);
        send_msg(0, 0);
        chk("model_full64_n", 64'(chk_q.size()), 64'd32);
        chk("model_full64_b16", chk_q[16].d, 64'h80000000);
        chk("model_full64_b31", chk_q[31].d, 64'h200);
        chk("model_full64_f15", 64'({chk_q[15].blk, chk_q[15].lst}), 64'b10);
        wait_drain(0);

        // 56 bytes: 0x80 beyond the length slot, zeros spill into a second block
        msg_rep(32'h01020304, 14);
        send_msg(0, 0);
        chk("model_56_b14", chk_q[14].d, 64'h80000000);
        chk("model_56_b31", chk_q[31].d, 64'h1C0);
        wait_drain(0);

        // 'abc', 64-bit
        msg_abc();
        send_msg(1, 0);
        chk("model_abc64_n", 64'(chk_q.size()), 64'd8);
        chk("model_abc64_b0", chk_q[0].d, 64'h6162638000000000);
        chk("model_abc64_b7", chk_q[7].d, 64'h18);
        wait_drain(1);

        // Stall output beats 3-5
        bp_base = out_cnt32;
        last_st = -1;
        bp_mode = 1;
        msg_abc();
        send_msg(0, 0);
        wait_drain(0);

        // Periodic backpressure with input gaps in DATA
        bp_mode = 2;
        msg_rep(32'h61626364, 16);
        send_msg(0, 1);
        wait_drain(0);
        bp_mode = 0;

        // 53 bytes: 0x80 on beat 13, straight to the length beats
        msg_seq(53);
        send_msg(0, 0);
        chk("model_53_n", 64'(chk_q.size()), 64'd16);
        chk("model_53_b13", chk_q[13].d, 64'h35800000);
        chk("model_53_b15", chk_q[15].d, 64'h1A8);
        wait_drain(0);

        // 64-bit: full 64-byte message, then 50 bytes ending on beat 6
        msg_seq(64);
        send_msg(1, 0);
        chk("model_64b_b8", chk_q[8].d, 64'h8000000000000000);
        chk("model_64b_b15", chk_q[15].d, 64'h200);
        wait_drain(1);
        msg_seq(50);
        send_msg(1, 0);
        chk("model_50_b6", chk_q[6].d, 64'h3132800000000000);
        chk("model_50_b7", chk_q[7].d, 64'h190);
        wait_drain(1);

        // Back-to-back messages
        msg_abc();
        send_msg(0, 0);
        msg_seq(5);
        send_msg(0, 0);
        wait_drain(0);

        // Reset during PAD_00 of the 64-byte message
        msg_rep(32'h61626364, 16);
        send_msg(0, 0);
        repeat (4) @(posedge clk);
        #3;
        chk("pad_rdy32", 64'(m32_rdy), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_d32", 64'(o32_d), 64'd0);
        chk("midrst_ctl32", 64'({o32_vld, o32_blk, o32_lst}), 64'd0);
        chk("midrst_rdy32", 64'(m32_rdy), 64'd0);
        exp32.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        msg_abc();
        send_msg(0, 0);
        wait_drain(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
